// File: rtl/cpu_pkg.sv
// Shared state encodings and grant-select constants for the memory arbiter.
// Pure declarations: no latency, no flow control.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin tie breaker; the grant decision is combinational and the last-grant bit is registered.
// Lone requests win at once; on a tie the port not granted last wins.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic upd,
  input  logic upd_gnt,
  output logic gnt,
  output logic gnt_vld
);

  logic last;

  // Reset points last at data so that the first tie goes to fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= GNT_D;
    end else if (upd) begin
      last <= upd_gnt;
    end
  end

  always_comb begin
    gnt_vld = i_req | d_req;
    gnt     = GNT_I;
    if (i_req && d_req) begin
      gnt = (last == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory command bus; request to done takes 3 cycles minimum.
// m_busy holds the command low in ISSUE; the transaction is aborted with err if m_ready does not arrive in time.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        m_read,
  output logic        m_write,
  output logic        m_instr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_busy,
  input  logic        m_cack,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        err
);

  // err lands TIMEOUT cycles after the m_cack cycle, so the last WAIT cycle sees cnt == TIMEOUT-2.
  localparam int LAST = (TIMEOUT > 1) ? TIMEOUT - 2 : 0;
  localparam int CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          cur_we;
  logic          arb_gnt;
  logic          arb_vld;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .d_req   (d_req),
    .upd     (state == ST_DONE),
    .upd_gnt (m_instr ? GNT_I : GNT_D),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  assign m_read  = (state == ST_ISSUE) && !m_busy && !cur_we;
  assign m_write = (state == ST_ISSUE) && !m_busy && cur_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_we  <= 1'b0;
      m_instr <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            if (arb_gnt == GNT_I) begin
              m_instr <= 1'b1;
              m_addr  <= i_addr;
              m_wdata <= '0;
              cur_we  <= 1'b0;
            end else begin
              m_instr <= 1'b0;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              cur_we  <= d_we;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An acknowledge only counts while the command is actually on the bus.
          if (!m_busy && m_cack) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_ready) begin
            if (m_instr) begin
              i_rdata <= m_rdata;
              i_done  <= 1'b1;
            end else begin
              if (!cur_we) begin
                d_rdata <= m_rdata[15:0];
              end
              d_done <= 1'b1;
            end
            state <= ST_DONE;
          end else if (cnt == CW'(LAST)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench: stimulus pushes expected completions, a memory model answers commands,
// and a monitor pops and compares on every done/err pulse.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req;
  logic [15:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        m_read;
  logic        m_write;
  logic        m_instr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_busy;
  logic        m_cack;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        err;

  typedef struct {
    bit          port;    // 0 fetch, 1 data
    bit          to;      // memory never answers
    bit          we;
    bit          lat;     // check minimum request-to-done latency
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [31:0] rdata;
    int          req_cyc;
  } exp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int iss_i = 0;
  int fin_i = 0;
  int iss_d = 0;
  int fin_d = 0;

  exp_t q[$];
  exp_t plan_i;
  exp_t plan_d;
  exp_t cur;
  bit   mem_en    = 1'b1;
  bit   fast      = 1'b1;
  bit   man_ready = 1'b0;
  bit   last_d    = 1'b1;
  int   busy_lo   = -10;
  int   busy_hi   = -10;
  int   phase     = 0;
  int   rdy_cnt   = 0;
  int   cack_cyc  = 0;
  int   rdy_cyc   = 0;
  logic [31:0] exp_i = '0;
  logic [15:0] exp_d = '0;

  assign i_req = (iss_i != fin_i);
  assign d_req = (iss_d != fin_d);

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .m_read  (m_read),
    .m_write (m_write),
    .m_instr (m_instr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_busy  (m_busy),
    .m_cack  (m_cack),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_read"},  32'(m_read),  32'd0);
    check({tag, "_m_write"}, 32'(m_write), 32'd0);
    check({tag, "_m_instr"}, 32'(m_instr), 32'd0);
    check({tag, "_m_addr"},  32'(m_addr),  32'd0);
    check({tag, "_m_wdata"}, 32'(m_wdata), 32'd0);
    check({tag, "_i_rdata"}, i_rdata,      32'd0);
    check({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
    check({tag, "_i_done"},  32'(i_done),  32'd0);
    check({tag, "_d_done"},  32'(d_done),  32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
  endtask

  // Reference: lone request wins; on a tie the port not last completed wins.
  task automatic push(input exp_t e);
    q.push_back(e);
    if (!e.to) last_d = e.port;
  endtask

  task automatic issue(input int pat, input bit toi, input bit tod, input bit lat,
                       input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dw,
                       input bit dwe, input logic [31:0] ird, input logic [31:0] drd);
    exp_t ei;
    exp_t ed;
    @(posedge clk); #1;
    ei = '{port: 1'b0, to: toi, we: 1'b0, lat: lat, addr: ia, wdata: 16'h0, rdata: ird, req_cyc: cyc};
    ed = '{port: 1'b1, to: tod, we: dwe,  lat: lat, addr: da, wdata: dw,    rdata: drd, req_cyc: cyc};
    plan_i = ei;
    plan_d = ed;
    i_addr = ia;
    d_addr = da;
    d_wdata = dw;
    d_we = dwe;
    if (pat == 3) begin
      if (last_d) begin push(ei); push(ed); end
      else        begin push(ed); push(ei); end
    end else if (pat == 1) begin
      push(ei);
    end else begin
      push(ed);
    end
    if ((pat & 1) != 0) iss_i++;
    if ((pat & 2) != 0) iss_d++;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((iss_i != fin_i || iss_d != fin_d) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_idle: transactions still pending after %0d cycles, required 0 pending", k);
    end
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic rand_scn();
    issue($urandom_range(1, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 1'b0,
          16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1,
          $urandom, $urandom);
    wait_idle();
  endtask

  // Memory model: answers each command using the plan of the port that m_instr names.
  initial begin
    m_busy = 1'b0;
    m_cack = 1'b0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_en) begin
        m_busy = 1'b0;
        m_cack = 1'b0;
        m_ready = man_ready;
        phase = 0;
        continue;
      end
      m_cack = 1'b0;
      m_ready = 1'b0;
      m_rdata = $urandom;
      m_busy = (cyc >= busy_lo && cyc <= busy_hi) ? 1'b1 : (!fast && $urandom_range(0, 3) == 0);
      #1;
      if (phase == 0) begin
        if (m_read || m_write) begin
          cur = m_instr ? plan_i : plan_d;
          check("cmd_addr",  32'(m_addr),  32'(cur.addr));
          check("cmd_write", 32'(m_write), 32'(cur.we));
          check("cmd_read",  32'(m_read),  32'(!cur.we));
          if (cur.we) check("cmd_wdata", 32'(m_wdata), 32'(cur.wdata));
          if (fast || $urandom_range(0, 2) != 0) begin
            m_cack = 1'b1;
            cack_cyc = cyc;
            phase = cur.to ? 2 : 1;
            rdy_cnt = fast ? 0 : $urandom_range(0, 3);
          end
        end else if (!fast && !m_busy && $urandom_range(0, 7) == 0) begin
          m_cack = 1'b1;
        end
        if (!fast && $urandom_range(0, 7) == 0) m_ready = 1'b1;
      end else if (phase == 1) begin
        if (rdy_cnt == 0) begin
          m_ready = 1'b1;
          m_rdata = cur.rdata;
          rdy_cyc = cyc;
          phase = 0;
        end else begin
          rdy_cnt--;
          if (!fast && $urandom_range(0, 3) == 0) m_cack = 1'b1;
        end
      end else if (err) begin
        phase = 0;
      end
    end
  end

  // Monitor: every completion or abort pulse must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_i = '0;
        exp_d = '0;
        continue;
      end
      if (i_done || d_done || err) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: i_done=%b d_done=%b err=%b with nothing outstanding", i_done, d_done, err);
        end else begin
          e = q.pop_front();
          check("resp_i_done", 32'(i_done), 32'(!e.to && !e.port));
          check("resp_d_done", 32'(d_done), 32'(!e.to && e.port));
          check("resp_err",    32'(err),    32'(e.to));
          if (e.to) begin
            check("cack_to_err_cycles", 32'(cyc - cack_cyc), 32'(TO));
          end else begin
            check("ready_to_done_cycles", 32'(cyc - rdy_cyc), 32'd1);
            if (e.lat) check("req_to_done_cycles", 32'(cyc - e.req_cyc), 32'd3);
            if (!e.port) exp_i = e.rdata;
            else if (!e.we) exp_d = e.rdata[15:0];
          end
          check("i_rdata", i_rdata, exp_i);
          check("d_rdata", 32'(d_rdata), 32'(exp_d));
          if (e.port) fin_d++;
          else        fin_i++;
        end
      end
    end
  end

  initial begin
    int k;
    i_addr = '0;
    d_addr = '0;
    d_we = 1'b0;
    d_wdata = '0;
    #1 rst = 1'b0;
    #11 check_zero("reset");
    #10 rst = 1'b1;

    // Ties straight after reset: fetch, data, fetch, data.
    fast = 1'b1;
    issue(3, 0, 0, 0, 16'h0100, 16'h0200, 16'h0000, 1'b0, 32'h1111_2222, 32'h3333_4444);
    wait_idle();
    issue(3, 0, 0, 0, 16'h0104, 16'h0204, 16'h0000, 1'b0, 32'h5555_6666, 32'h7777_8888);
    wait_idle();

    // Fetch-only read with minimum latency.
    issue(1, 0, 0, 1, 16'h0010, 16'h0000, 16'h0000, 1'b0, 32'hDEAD_BEEF, 32'h0);
    wait_idle();

    // Data write held off by three busy cycles.
    busy_lo = cyc + 2;
    busy_hi = cyc + 4;
    issue(2, 0, 0, 0, 16'h0000, 16'h8000, 16'h1234, 1'b1, 32'h0, 32'hCAFE_F00D);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("busy_holds_m_write", 32'(m_write), 32'd0);
    end
    @(negedge clk);
    check("m_write_after_busy", 32'(m_write), 32'd1);
    wait_idle();

    // Fetch that never gets m_ready, then normal traffic.
    issue(1, 1, 0, 0, 16'h0020, 16'h0000, 16'h0000, 1'b0, 32'hBAD0_BAD0, 32'h0);
    wait_idle();
    issue(1, 0, 0, 1, 16'h0024, 16'h0000, 16'h0000, 1'b0, 32'h0BAD_F00D, 32'h0);
    wait_idle();

    fast = 1'b0;
    for (int n = 0; n < 40; n++) rand_scn();

    // Reset while the memory is holding a fetch in WAIT.
    fast = 1'b1;
    @(posedge clk); #1;
    plan_i = '{port: 1'b0, to: 1'b1, we: 1'b0, lat: 1'b0, addr: 16'h0abc, wdata: 16'h0, rdata: 32'h0, req_cyc: cyc};
    i_addr = 16'h0abc;
    iss_i++;
    k = 0;
    while (phase != 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reached_wait", 32'(phase), 32'd2);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("async_reset");
    iss_i = fin_i;
    mem_en = 1'b0;
    man_ready = 1'b1;
    last_d = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("stale_ready_no_pulse", 32'(i_done | d_done | err), 32'd0);
      if (j == 1) man_ready = 1'b0;
    end
    mem_en = 1'b1;

    // First tie after this reset goes to fetch again.
    issue(3, 0, 0, 0, 16'h0300, 16'h0400, 16'h5a5a, 1'b1, 32'h1357_9bdf, 32'h0);
    wait_idle();
    fast = 1'b0;
    for (int n = 0; n < 10; n++) rand_scn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
